// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART message sequencer slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    REPEAT_WAIT
  } state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_GAP_CYCLES = 10;
  localparam int DEF_REPEAT_GAP = 1000000;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

endpackage

// File: rtl/uart_msg_ram.sv
// Message buffer: one write port, registered read port.
// A write to the address being read returns the new data on the next cycle.
module uart_msg_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/uart_msg_sequencer.sv
// Feeds a byte-wide UART one buffered character at a time, with
// per-character and per-pass idle gaps, single-shot or repeating.
module uart_msg_sequencer
  import uart_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int REPEAT_GAP = DEF_REPEAT_GAP,
  parameter int CNT_W      = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_repeat,
  input  logic              abort,
  input  logic [ADDR_W:0]   msg_len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tx_ready,
  output logic              tx_send,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output state_t            state
);

  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'((REPEAT_GAP > 0) ? REPEAT_GAP - 1 : 0);
  localparam state_t ENTRY    = (GAP_CYCLES == 0) ? SEND : GAP;
  localparam state_t REP_NEXT = (REPEAT_GAP == 0) ? ENTRY : REPEAT_WAIT;

  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   eff_len;
  logic [CNT_W-1:0]  counter;
  logic [DATA_W-1:0] rd_data;
  logic              last_char;
  logic              advance;

  assign busy      = (state != IDLE);
  assign last_char = ({1'b0, index} + 1'b1) >= eff_len;
  assign advance   = (state == WAIT_DONE) && tx_ready && !last_char;
  // Read the upcoming index one cycle early so the gap hides the RAM latency.
  assign rd_addr   = advance ? index + 1'b1 : index;

  uart_msg_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en && !busy),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // UART handshake: a character is handed off with a one-cycle tx_send only
  // when tx_ready was high; it is complete once tx_ready goes low then high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      index   <= '0;
      counter <= '0;
      eff_len <= '0;
      tx_send <= 1'b0;
      tx_data <= '0;
      done    <= 1'b0;
    end else begin
      tx_send <= 1'b0;
      done    <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        index   <= '0;
        counter <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && (msg_len != '0)) begin
              eff_len <= (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
              counter <= '0;
              state   <= ENTRY;
            end
          end
          GAP: begin
            if (counter == GAP_LAST) begin
              counter <= '0;
              if (tx_ready) begin
                tx_send <= 1'b1;
                tx_data <= rd_data;
                state   <= WAIT_BUSY;
              end else begin
                state <= SEND;
              end
            end else begin
              counter <= counter + 1'b1;
            end
          end
          SEND: begin
            if (tx_ready) begin
              tx_send <= 1'b1;
              tx_data <= rd_data;
              state   <= WAIT_BUSY;
            end
          end
          WAIT_BUSY: begin
            if (!tx_ready) state <= WAIT_DONE;
          end
          WAIT_DONE: begin
            if (tx_ready) begin
              counter <= '0;
              if (!last_char) begin
                index <= index + 1'b1;
                state <= ENTRY;
              end else begin
                done  <= 1'b1;
                index <= '0;
                state <= mode_repeat ? REP_NEXT : IDLE;
              end
            end
          end
          REPEAT_WAIT: begin
            if (!mode_repeat) begin
              counter <= '0;
              state   <= IDLE;
            end else if (counter == REP_LAST) begin
              counter <= '0;
              state   <= ENTRY;
            end else begin
              counter <= counter + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Bench for uart_msg_sequencer: timestamp-based reference model, UART
// responder, directed scenarios and a randomized phase.
module tb_uart_msg_sequencer;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int G     = 10;
  localparam int R     = 50;

  localparam int M_IDLE   = 0;
  localparam int M_PEND   = 1;
  localparam int M_FLIGHT = 2;
  localparam int M_REP    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode_repeat = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   msg_len = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          tx_ready = 1'b1;
  logic          tx_send;
  logic [DW-1:0] tx_data;
  logic          busy;
  logic          done;
  state_t        state;

  uart_msg_sequencer #(
    .DATA_W (DW), .DEPTH (DEPTH), .ADDR_W (AW),
    .GAP_CYCLES (G), .REPEAT_GAP (R), .CNT_W (24)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .mode_repeat (mode_repeat),
    .abort (abort), .msg_len (msg_len), .wr_en (wr_en), .wr_addr (wr_addr),
    .wr_data (wr_data), .tx_ready (tx_ready), .tx_send (tx_send),
    .tx_data (tx_data), .busy (busy), .done (done), .state (state)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vecs++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: expected outputs for the next cycle, from timestamps.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] pass_all[$];
  logic [DW-1:0] pass_q[$];
  int            m_phase = M_IDLE;
  int            send_at = 0;
  int            rep_end = 0;
  int            n_len = 0;
  bit            low_seen = 0;
  logic          exp_send = 0, exp_done = 0, exp_busy = 0;
  logic [DW-1:0] exp_data = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase  = M_IDLE;
      exp_send = 0;
      exp_done = 0;
      exp_busy = 0;
      exp_data = '0;
      pass_q.delete();
    end else begin
      exp_send = 0;
      exp_done = 0;
      if (m_phase == M_IDLE && wr_en) m_mem[wr_addr] = wr_data;
      if (abort) begin
        m_phase = M_IDLE;
        pass_q.delete();
      end else begin
        case (m_phase)
          M_IDLE: if (start && msg_len != 0) begin
            n_len = (int'(msg_len) > DEPTH) ? DEPTH : int'(msg_len);
            pass_all.delete();
            for (int i = 0; i < n_len; i++) pass_all.push_back(m_mem[i]);
            pass_q  = pass_all;
            send_at = cyc + 1 + G;
            m_phase = M_PEND;
          end
          M_PEND: if (cyc + 1 >= send_at && tx_ready) begin
            exp_send = 1;
            exp_data = pass_q.pop_front();
            low_seen = 0;
            m_phase  = M_FLIGHT;
          end
          M_FLIGHT: begin
            if (!low_seen) begin
              if (!tx_ready) low_seen = 1;
            end else if (tx_ready) begin
              if (pass_q.size() > 0) begin
                send_at = cyc + 1 + G;
                m_phase = M_PEND;
              end else begin
                exp_done = 1;
                if (mode_repeat) begin
                  pass_q  = pass_all;
                  rep_end = cyc + R;
                  m_phase = M_REP;
                end else begin
                  m_phase = M_IDLE;
                end
              end
            end
          end
          M_REP: begin
            if (!mode_repeat) m_phase = M_IDLE;
            else if (cyc == rep_end) begin
              send_at = cyc + 1 + G;
              m_phase = M_PEND;
            end
          end
          default: m_phase = M_IDLE;
        endcase
      end
      exp_busy = (m_phase != M_IDLE);
    end
  end

  // Compare process and transfer log.
  logic [DW-1:0] sent_q[$];
  int            sent_cyc_q[$];
  int            done_cyc_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_send", tx_send, exp_send);
      check("tx_data", tx_data, exp_data);
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
    end
    if (tx_send === 1'b1) begin
      sent_q.push_back(tx_data);
      sent_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) done_cyc_q.push_back(cyc);
  end

  // UART responder: holds tx_ready low after each handoff, optional random stalls.
  bit uart_fixed = 1;
  bit rand_stall = 0;
  int uart_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) tx_ready = 1'b1;
      end else if (tx_send === 1'b1) begin
        tx_ready = 1'b0;
        uart_cnt = uart_fixed ? 20 : $urandom_range(1, 20);
      end else if (rand_stall && $urandom_range(0, 15) == 0) begin
        tx_ready = 1'b0;
        uart_cnt = $urandom_range(1, 4);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic write_byte(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  int start_cyc = 0;
  task automatic pulse_start(input int len);
    msg_len = (AW + 1)'(len); start = 1'b1; start_cyc = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin step(1); n++; end
    check(name, (n < budget), 1);
  endtask

  task automatic wait_sends(input int k, input int budget, input string name);
    int n = 0;
    while (sent_q.size() < k && n < budget) begin step(1); n++; end
    check(name, (n < budget), 1);
  endtask

  task automatic wait_dones(input int k, input int budget, input string name);
    int n = 0;
    while (done_cyc_q.size() < k && n < budget) begin step(1); n++; end
    check(name, (n < budget), 1);
  endtask

  logic [DW-1:0] hello [6] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, ASCII_LF};

  initial begin
    int base, dbase;
    step(2);
    chk_en = 1;
    check("reset tx_send", tx_send, 0);
    check("reset tx_data", tx_data, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset state", state, IDLE);
    reset = 1'b0;
    step(2);

    // Single pass of "hello\n"
    for (int i = 0; i < 6; i++) write_byte(i, hello[i]);
    base = sent_q.size(); dbase = done_cyc_q.size();
    pulse_start(6);
    wait_idle(2000, "hello completes");
    check("hello send count", sent_q.size() - base, 6);
    for (int i = 0; i < 6; i++) check($sformatf("hello char %0d", i), sent_q[base + i], hello[i]);
    check("hello first latency", sent_cyc_q[base] - start_cyc, G + 1);
    check("hello done count", done_cyc_q.size() - dbase, 1);

    // Repeat mode, stopped during the second pass
    mode_repeat = 1'b1;
    base = sent_q.size(); dbase = done_cyc_q.size();
    pulse_start(6);
    wait_dones(dbase + 1, 2000, "repeat pass1 done");
    wait_sends(base + 7, 500, "repeat pass2 start");
    check("repeat gap", sent_cyc_q[base + 6] - done_cyc_q[dbase], R + G);
    check("repeat pass2 char0", sent_q[base + 6], 8'h68);
    mode_repeat = 1'b0;
    wait_idle(2000, "repeat stops");
    check("repeat send count", sent_q.size() - base, 12);
    check("repeat done count", done_cyc_q.size() - dbase, 2);

    // Abort while the second character is in flight
    base = sent_q.size(); dbase = done_cyc_q.size();
    pulse_start(6);
    wait_sends(base + 2, 500, "abort reach char1");
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort busy", busy, 0);
    step(60);
    check("abort send count", sent_q.size() - base, 2);
    check("abort no done", done_cyc_q.size() - dbase, 0);
    base = sent_q.size();
    pulse_start(6);
    wait_idle(2000, "after abort completes");
    check("after abort char0", sent_q[base], 8'h68);
    check("after abort count", sent_q.size() - base, 6);

    // Zero length and over-length
    base = sent_q.size();
    pulse_start(0);
    step(20);
    check("len0 busy", busy, 0);
    check("len0 sends", sent_q.size() - base, 0);
    for (int i = 6; i < DEPTH; i++) write_byte(i, DW'($urandom_range(0, 255)));
    base = sent_q.size(); dbase = done_cyc_q.size();
    pulse_start(20);
    wait_idle(3000, "len20 completes");
    check("len20 sends", sent_q.size() - base, DEPTH);
    check("len20 done", done_cyc_q.size() - dbase, 1);

    // Writes while busy are dropped; a write with start lands first
    pulse_start(6);
    step(3);
    write_byte(0, 8'h41);
    wait_idle(2000, "busy write pass");
    base = sent_q.size();
    pulse_start(6);
    wait_sends(base + 1, 500, "post busy write send");
    check("busy write dropped", sent_q[base], 8'h68);
    wait_idle(2000, "post busy write idle");
    base = sent_q.size();
    wr_en = 1'b1; wr_addr = '0; wr_data = 8'h41;
    pulse_start(6);
    wr_en = 1'b0;
    wait_sends(base + 1, 500, "idle write send");
    check("idle write lands", sent_q[base], 8'h41);
    wait_idle(2000, "idle write pass");

    // Reset in the middle of a character
    pulse_start(6);
    wait_sends(sent_q.size() + 1, 500, "reset mid char reach");
    step(2);
    reset = 1'b1;
    #1;
    check("mid reset tx_send", tx_send, 0);
    check("mid reset tx_data", tx_data, 0);
    check("mid reset busy", busy, 0);
    check("mid reset done", done, 0);
    step(2);
    reset = 1'b0;
    step(25);
    base = sent_q.size();
    pulse_start(6);
    wait_idle(2000, "post reset pass");
    check("post reset count", sent_q.size() - base, 6);
    check("post reset char0", sent_q[base], 8'h41);

    // Randomized phase
    uart_fixed = 0;
    rand_stall = 1;
    for (int c = 0; c < 3000; c++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_data = DW'($urandom_range(0, 255));
      start   = ($urandom_range(0, 19) == 0);
      msg_len = (AW + 1)'($urandom_range(0, 20));
      abort   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) mode_repeat = ~mode_repeat;
      step(1);
    end
    wr_en = 1'b0; start = 1'b0; mode_repeat = 1'b0;
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    wait_idle(10, "random end idle");
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    errs++;
    $display("FAIL global_timeout: got running expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_msg_sequencer.md
Name: uart_msg_sequencer

Overview:
Parametrised message sequencer that feeds a byte-wide UART transmitter one character at a time from a writable message buffer.
- Supports single-shot and continuous-repeat modes, a programmable inter-character gap and a programmable inter-message gap.
- Provides a start/abort/busy/done control interface.
- Sits between board-level control logic (buttons, LEDs) and the existing uart_tx transmitter, connecting to its tx_data/tx_send/tx_ready handshake.

Parameters:
- DATA_W, 8, character width in bits.
- DEPTH, 16, message buffer entries; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), buffer address width and length-field width minus one.
- GAP_CYCLES, 10, idle clocks before each character handoff; 0 means no gap.
- REPEAT_GAP, 1000000, idle clocks between passes in repeat mode.
- CNT_W, 24, width of the shared gap counter; must hold max(GAP_CYCLES, REPEAT_GAP).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle request to begin a pass; sampled only in IDLE.
- mode_repeat, in, 1, 1 = repeat passes until abort or deassertion; sampled at each pass end.
- abort, in, 1, stops the sequence; takes priority over all other inputs.
- msg_len, in, ADDR_W+1, number of characters per pass; sampled on accepted start.
- wr_en, in, 1, buffer write strobe.
- wr_addr, in, ADDR_W, buffer write address.
- wr_data, in, DATA_W, buffer write data.
- tx_ready, in, 1, UART idle/ready indication.
- tx_send, out, 1, one-cycle send pulse to the UART.
- tx_data, out, DATA_W, character presented to the UART; stable from the tx_send cycle until the next handoff.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse at the end of each completed pass.

Behaviour:
- Reset values: tx_send=0, tx_data=0, busy=0, done=0, state=IDLE, index=0, counter=0. Buffer contents are not reset.
- States:
  - IDLE: wait for start.
  - GAP: count GAP_CYCLES.
  - SEND: wait for tx_ready, then pulse tx_send.
  - WAIT_BUSY: wait for tx_ready low.
  - WAIT_DONE: wait for tx_ready high.
  - REPEAT_WAIT: count REPEAT_GAP.
- IDLE -> GAP on start when 1 <= eff_len. eff_len = min(msg_len, DEPTH), latched on the accepted start. A start with msg_len=0 is ignored: no busy, no done.
- GAP: counter runs 0..GAP_CYCLES-1, then -> SEND. If GAP_CYCLES=0, enter SEND directly.
- SEND: in the first cycle with tx_ready=1, drive tx_data=buf[index] and tx_send=1 for exactly one cycle, then -> WAIT_BUSY. With tx_ready=1 throughout, tx_send for char 0 is high in cycle t+1+GAP_CYCLES after start at cycle t.
- WAIT_BUSY -> WAIT_DONE when tx_ready=0.
- WAIT_DONE, on tx_ready=1:
  - If index < eff_len-1: index++ and -> GAP.
  - Otherwise: pulse done. If mode_repeat=1, -> REPEAT_WAIT with index=0; else -> IDLE with index=0.
- REPEAT_WAIT: counter runs 0..REPEAT_GAP-1, then -> GAP. If mode_repeat drops during REPEAT_WAIT, -> IDLE at the next cycle.
- abort in any state: next state IDLE, tx_send=0, index=0, counter cleared, no done pulse. A character already handed off completes inside the UART.
- Simultaneous abort and start in IDLE: abort wins, and the block stays IDLE.
- Buffer writes:
  - Accepted only when busy=0; writes while busy are dropped.
  - A write and a start in the same IDLE cycle: the write lands, and the pass reads the new value.
- Reset mid-pass: immediate return to reset values. tx_send never glitches high during reset.
- tx_send is never asserted twice for one character. Only one handoff is outstanding at a time.

Decomposition:
- Package uart_pkg:
  - State enum: IDLE, GAP, SEND, WAIT_BUSY, WAIT_DONE, REPEAT_WAIT.
  - Default constants: DATA_W, GAP_CYCLES, REPEAT_GAP.
  - ASCII constants: newline, carriage return.
- Sub-module uart_msg_ram:
  - DEPTH x DATA_W single-write-port buffer.
  - Asynchronous or registered read; the registered variant is used, with its one-cycle latency absorbed in GAP/SEND.
- The FSM, counter and index stay in uart_msg_sequencer.

Test Plan:
- Write "hello\n" at addresses 0..5, msg_len=6, GAP_CYCLES=10, start pulse, UART model holding tx_ready low for 20 clocks per character -> exactly 6 tx_send pulses with data 0x68 0x65 0x6C 0x6C 0x6F 0x0A, one done pulse after the 6th, busy low afterwards.
- Same setup with mode_repeat=1 and REPEAT_GAP=50 -> second pass begins with 0x68 after 50+GAP_CYCLES idle clocks, and done pulses once per pass. Deassert mode_repeat during the second pass -> stops after the 6th character, back to IDLE.
- abort asserted while in WAIT_BUSY of character 2 -> IDLE next cycle, no further tx_send, no done. A following start resends from 0x68.
- msg_len=0 with start -> busy stays 0, no tx_send. msg_len=20 with DEPTH=16 -> exactly 16 characters sent.
- wr_en to address 0 with 0x41 while busy -> buffer unchanged, so the next pass sends 0x68. The same write in IDLE -> the next pass sends 0x41 first.
- reset asserted mid-character -> all outputs at reset values in the same cycle. After release, a fresh start transmits correctly.
